ws2812_strip_ctrl: RTL and testbench



---
 rtl/ws2812_pkg.sv | 29 ++
 rtl/ws2812_strip_ctrl_if.sv | 23 ++
 rtl/ws2812_bit_timer.sv | 46 ++++
 rtl/ws2812_strip_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ws2812_strip_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// Shared constants, state encoding and sizing helpers for the WS2812B strip controller.
package ws2812_pkg;

    localparam int COLOR_W          = 24;
    localparam int T1H_DEF          = 40;
    localparam int T1L_DEF          = 20;
    localparam int T0H_DEF          = 20;
    localparam int T0L_DEF          = 40;
    localparam int RESET_CYCLES_DEF = 3000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_BIT_HI = 3'd3,
        ST_BIT_LO = 3'd4,
        ST_LATCH  = 3'd5
    } state_t;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_strip_ctrl_if.sv
// Pixel-memory read port: strobe and address out, GRB word back one cycle later.
interface ws2812_strip_ctrl_if #(
    parameter int ADDR_W = 6
) ();
    import ws2812_pkg::*;

    logic                pix_rd;
    logic [ADDR_W-1:0]   pix_addr;
    logic [COLOR_W-1:0]  pix_data;

    modport master (
        output pix_rd,
        output pix_addr,
        input  pix_data
    );

    modport slave (
        input  pix_rd,
        input  pix_addr,
        output pix_data
    );

endinterface

// File: rtl/ws2812_bit_timer.sv
// One WS2812B bit cell: high phase then low phase, lengths chosen by the bit value.
// The counter restarts at zero on the cycle after bit_done, so consecutive bits abut.
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int T1H = T1H_DEF,
    parameter int T1L = T1L_DEF,
    parameter int T0H = T0H_DEF,
    parameter int T0L = T0L_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_go,
    input  logic i_bit,
    output logic o_level,
    output logic o_hi_end,
    output logic o_bit_done
);

    localparam int CNT_W = cnt_width(imax(T1H + T1L, T0H + T0L));

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_hi_len;
    logic [CNT_W-1:0] w_bit_len;

    // Phase lengths for the current bit and the derived line level / phase-end flags.
    always_comb begin
        w_hi_len   = i_bit ? CNT_W'(T1H) : CNT_W'(T0H);
        w_bit_len  = i_bit ? CNT_W'(T1H + T1L) : CNT_W'(T0H + T0L);
        o_level    = i_go && (r_cnt < w_hi_len);
        o_hi_end   = i_go && (r_cnt == w_hi_len - CNT_W'(1));
        o_bit_done = i_go && (r_cnt == w_bit_len - CNT_W'(1));
    end

    // Cycle counter within the bit cell; idles at zero when not driving bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_go || o_bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ws2812_strip_ctrl.sv
// WS2812B frame scheduler: fetches one GRB word per LED, shifts it out MSB-first,
// prefetches the next word during bit 23, then holds the line low for the latch time.
module ws2812_strip_ctrl
    import ws2812_pkg::*;
#(
    parameter int MAX_LEDS     = 64,
    parameter int ADDR_W       = 6,
    parameter int T1H          = T1H_DEF,
    parameter int T1L          = T1L_DEF,
    parameter int T0H          = T0H_DEF,
    parameter int T0L          = T0L_DEF,
    parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W:0]         num_leds,
    ws2812_strip_ctrl_if.master     pix,
    output logic                    busy,
    output logic                    done,
    output logic                    out
);

    localparam int LAT_W = cnt_width(imax(RESET_CYCLES, imax(T1H + T1L, T0H + T0L)));
    localparam logic [ADDR_W:0] MAX_N    = (ADDR_W + 1)'(MAX_LEDS);
    localparam logic [4:0]      BIT_MSB  = 5'(COLOR_W - 1);

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_W:0]      r_n;
    logic [ADDR_W-1:0]    r_pix;
    logic [4:0]           r_bit;
    logic [COLOR_W-1:0]   r_sr;
    logic [COLOR_W-1:0]   r_next_pix;
    logic                 r_first;
    logic                 r_pf_cap;
    logic                 r_done;
    logic [LAT_W-1:0]     r_lat;

    logic                 w_go;
    logic                 w_level;
    logic                 w_hi_end;
    logic                 w_bit_done;
    logic [ADDR_W:0]      w_pix_inc;
    logic                 w_more;
    logic                 w_accept;
    logic                 w_pf;
    logic                 w_last_bit;
    logic                 w_lat_end;

    ws2812_bit_timer #(
        .T1H (T1H),
        .T1L (T1L),
        .T0H (T0H),
        .T0L (T0L)
    ) u_bit_timer (
        .clk        (CLOCK_50),
        .rst        (reset),
        .i_go       (w_go),
        .i_bit      (r_sr[COLOR_W-1]),
        .o_level    (w_level),
        .o_hi_end   (w_hi_end),
        .o_bit_done (w_bit_done)
    );

    // Shared decode of the current state and indices.
    always_comb begin
        w_go       = (r_state == ST_BIT_HI) || (r_state == ST_BIT_LO);
        w_pix_inc  = {1'b0, r_pix} + (ADDR_W + 1)'(1);
        w_more     = w_pix_inc < r_n;
        w_accept   = (r_state == ST_IDLE) && start && (num_leds != '0) && !r_done;
        // Prefetch fires only on the first cycle of bit 23, hence r_first.
        w_pf       = (r_state == ST_BIT_HI) && r_first && w_more;
        w_last_bit = (r_bit == '0);
        w_lat_end  = (r_state == ST_LATCH) && (r_lat == LAT_W'(RESET_CYCLES - 1));
    end

    // Output drive: all outputs decode registered state, so reset clears them at once.
    always_comb begin
        pix.pix_rd   = (r_state == ST_PRIME) || w_pf;
        pix.pix_addr = w_pf ? w_pix_inc[ADDR_W-1:0] : '0;
        busy         = (r_state != ST_IDLE);
        done         = r_done;
        out          = w_level;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_PRIME;
            ST_PRIME:  w_next = ST_LOAD;
            ST_LOAD:   w_next = ST_BIT_HI;
            ST_BIT_HI: if (w_hi_end) w_next = ST_BIT_LO;
            ST_BIT_LO: begin
                if (w_bit_done) begin
                    if (!w_last_bit || w_more) w_next = ST_BIT_HI;
                    else                       w_next = ST_LATCH;
                end
            end
            ST_LATCH:  if (w_lat_end) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Frame length latch, shift register, pixel/bit indices and prefetch capture.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_n        <= '0;
            r_pix      <= '0;
            r_bit      <= '0;
            r_sr       <= '0;
            r_next_pix <= '0;
            r_first    <= 1'b0;
            r_pf_cap   <= 1'b0;
        end else begin
            r_first  <= 1'b0;
            r_pf_cap <= w_pf;
            if (w_accept) r_n <= (num_leds > MAX_N) ? MAX_N : num_leds;
            if (r_pf_cap) r_next_pix <= pix.pix_data;
            case (r_state)
                ST_LOAD: begin
                    r_sr    <= pix.pix_data;
                    r_bit   <= BIT_MSB;
                    r_pix   <= '0;
                    r_first <= 1'b1;
                end
                ST_BIT_LO: begin
                    if (w_bit_done) begin
                        if (!w_last_bit) begin
                            r_sr  <= {r_sr[COLOR_W-2:0], 1'b0};
                            r_bit <= r_bit - 5'd1;
                        end else if (w_more) begin
                            r_sr    <= r_next_pix;
                            r_bit   <= BIT_MSB;
                            r_pix   <= w_pix_inc[ADDR_W-1:0];
                            r_first <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Latch interval counter and the one-cycle done pulse that follows it.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_lat  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_lat_end;
            if ((r_state == ST_LATCH) && !w_lat_end) r_lat <= r_lat + LAT_W'(1);
            else                                     r_lat <= '0;
        end
    end

endmodule

// File: tb/tb_ws2812_strip_ctrl.sv
// Self-checking bench for ws2812_strip_ctrl: one instance at default timing with a
// bit-level scoreboard, one at short timing for the MAX_LEDS clamp frame.
module tb_ws2812_strip_ctrl;
    import ws2812_pkg::*;

    localparam int AW = 6;

    typedef struct {
        int          num;
        logic [23:0] w0;
        logic [23:0] w1;
        logic [23:0] w2;
        int          exp_n;
        int          exp_busy;
        int          exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_f = 1'b0;
    logic [AW:0] num_leds = '0;
    logic [AW:0] num_leds_f = '0;
    logic busy, done, out;
    logic busy_f, done_f, out_f;

    logic [23:0] mem   [64];
    logic [23:0] mem_f [64];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    int   q_addr[$];
    logic q_bit[$];
    int   q_addr_f[$];

    int   busy_cnt = 0, done_cnt = 0, first_rise = -1;
    int   hi_len = 0, lo_len = 0, last_tl = 0;
    logic prev_out = 1'b0, in_bit = 1'b0, cur_bit = 1'b0;
    int   busy_cnt_f = 0, done_cnt_f = 0, reads_f = 0;

    ws2812_strip_ctrl_if #(.ADDR_W(AW)) pix_if ();
    ws2812_strip_ctrl_if #(.ADDR_W(AW)) pix_if_f ();

    ws2812_strip_ctrl #(
        .MAX_LEDS (64),
        .ADDR_W   (AW)
    ) u_dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .start    (start),
        .num_leds (num_leds),
        .pix      (pix_if),
        .busy     (busy),
        .done     (done),
        .out      (out)
    );

    ws2812_strip_ctrl #(
        .MAX_LEDS     (64),
        .ADDR_W       (AW),
        .T1H          (4),
        .T1L          (2),
        .T0H          (2),
        .T0L          (4),
        .RESET_CYCLES (16)
    ) u_fast (
        .CLOCK_50 (clk),
        .reset    (rst),
        .start    (start_f),
        .num_leds (num_leds_f),
        .pix      (pix_if_f),
        .busy     (busy_f),
        .done     (done_f),
        .out      (out_f)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel memories with one-cycle read latency.
    always @(posedge clk) if (pix_if.pix_rd)   pix_if.pix_data   <= mem[pix_if.pix_addr];
    always @(posedge clk) if (pix_if_f.pix_rd) pix_if_f.pix_data <= mem_f[pix_if_f.pix_addr];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Default-timing monitor: pops expected addresses and bits as the DUT produces them.
    always @(negedge clk) begin
        if (rst) begin
            prev_out = 1'b0;
            in_bit   = 1'b0;
            hi_len   = 0;
            lo_len   = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (in_bit) chk("latch_low_cycles", lo_len, last_tl + 3000);
                in_bit = 1'b0;
            end
            if (pix_if.pix_rd) begin
                if (q_addr.size() == 0) chk("unexpected_pix_rd_addr", int'(pix_if.pix_addr), -1);
                else                    chk("pix_addr", int'(pix_if.pix_addr), q_addr.pop_front());
            end
            if (out && !prev_out) begin
                if (first_rise < 0) first_rise = cyc;
                if (in_bit) chk("low_cycles", lo_len, last_tl);
                if (q_bit.size() == 0) begin
                    chk("unexpected_bit_out", int'(out), 0);
                    cur_bit = 1'b0;
                end else begin
                    cur_bit = q_bit.pop_front();
                end
                hi_len = 1;
                in_bit = 1'b1;
            end else if (out) begin
                hi_len++;
            end else if (prev_out) begin
                chk("high_cycles", hi_len, cur_bit ? 40 : 20);
                last_tl = cur_bit ? 20 : 40;
                lo_len  = 1;
            end else if (in_bit) begin
                lo_len++;
            end
            prev_out = out;
        end
    end

    // Short-timing monitor: read addresses, busy length, done pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy_f) busy_cnt_f++;
            if (done_f) done_cnt_f++;
            if (pix_if_f.pix_rd) begin
                reads_f++;
                if (q_addr_f.size() == 0) chk("fast_unexpected_pix_rd", int'(pix_if_f.pix_addr), -1);
                else                      chk("fast_pix_addr", int'(pix_if_f.pix_addr), q_addr_f.pop_front());
            end
        end
    end

    task automatic push_expect(input int n);
        logic [23:0] w;
        for (int k = 0; k < n; k++) begin
            q_addr.push_back(k);
            w = mem[k];
            for (int b = 23; b >= 0; b--) q_bit.push_back(w[b]);
        end
    endtask

    task automatic pulse_start(input int num, output int c0);
        @(negedge clk);
        start    = 1'b1;
        num_leds = (AW + 1)'(num);
        c0       = cyc;
        @(negedge clk);
        start    = 1'b0;
        num_leds = 7'd5;
    endtask

    task automatic wait_done(input int lim, input logic fast);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if ((fast ? done_cnt_f : done_cnt) != 0) break;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(input int num, input int exp_n, input int exp_busy,
                             input int exp_done, input string tag);
        int c0;
        push_expect(exp_n);
        busy_cnt   = 0;
        done_cnt   = 0;
        first_rise = -1;
        pulse_start(num, c0);
        wait_done(exp_busy + 200, 1'b0);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, "_done_pulses"}, done_cnt, exp_done);
        chk({tag, "_reads_left"}, q_addr.size(), 0);
        chk({tag, "_bits_left"}, q_bit.size(), 0);
        if (exp_n > 0) chk({tag, "_start_latency"}, first_rise - c0, 3);
        else           chk({tag, "_no_out"}, first_rise, -1);
    endtask

    initial begin
        vec_t vecs[4];
        int   c0;

        vecs[0] = '{1, 24'hFF0000, 24'h000000, 24'h000000, 1, 4442, 1};
        vecs[1] = '{3, 24'h000001, 24'h800000, 24'hAAAAAA, 3, 7322, 1};
        vecs[2] = '{0, 24'h123456, 24'h000000, 24'h000000, 0, 0,    0};
        vecs[3] = '{2, 24'h5A3C96, 24'h0F0F0F, 24'h000000, 2, 5882, 1};

        // Reset values.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out",      int'(out), 0);
        chk("rst_busy",     int'(busy), 0);
        chk("rst_done",     int'(done), 0);
        chk("rst_pix_rd",   int'(pix_if.pix_rd), 0);
        chk("rst_pix_addr", int'(pix_if.pix_addr), 0);
        chk("rst_fast_out", int'(out_f), 0);
        chk("rst_fast_busy", int'(busy_f), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_out",  int'(out), 0);

        // Table-driven frames at default timing.
        for (int v = 0; v < 4; v++) begin
            mem[0] = vecs[v].w0;
            mem[1] = vecs[v].w1;
            mem[2] = vecs[v].w2;
            run_frame(vecs[v].num, vecs[v].exp_n, vecs[v].exp_busy, vecs[v].exp_done,
                      $sformatf("vec%0d", v));
        end

        // start pulsed repeatedly while busy, num_leds wandering: one frame only.
        mem[0] = 24'h123456;
        push_expect(1);
        busy_cnt = 0;
        done_cnt = 0;
        pulse_start(1, c0);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start    = (i % 5 == 0);
            num_leds = (AW + 1)'($urandom_range(0, 127));
        end
        start = 1'b0;
        wait_done(4442 + 200, 1'b0);
        chk("restart_busy_cycles", busy_cnt, 4442);
        chk("restart_done_pulses", done_cnt, 1);
        chk("restart_reads_left",  q_addr.size(), 0);
        chk("restart_bits_left",   q_bit.size(), 0);

        // Reset during pixel 1, bit 10 high phase; then a clean N=2 frame.
        mem[0] = 24'hC3A5F0;
        mem[1] = 24'h5A5A5A;
        push_expect(2);
        busy_cnt = 0;
        done_cnt = 0;
        pulse_start(2, c0);
        while (cyc < c0 + 2230) @(negedge clk);
        chk("midrst_pre_out", int'(out), 1);
        rst = 1'b1;
        #1;
        chk("midrst_out",    int'(out), 0);
        chk("midrst_busy",   int'(busy), 0);
        chk("midrst_pix_rd", int'(pix_if.pix_rd), 0);
        q_addr.delete();
        q_bit.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        run_frame(2, 2, 5882, 1, "after_rst");

        // num_leds above MAX_LEDS on the short-timing instance.
        for (int k = 0; k < 64; k++) begin
            mem_f[k] = 24'($urandom);
            q_addr_f.push_back(k);
        end
        busy_cnt_f = 0;
        done_cnt_f = 0;
        reads_f    = 0;
        @(negedge clk);
        start_f    = 1'b1;
        num_leds_f = 7'd100;
        @(negedge clk);
        start_f    = 1'b0;
        wait_done(9234 + 200, 1'b1);
        chk("clamp_busy_cycles", busy_cnt_f, 9234);
        chk("clamp_done_pulses", done_cnt_f, 1);
        chk("clamp_reads",       reads_f, 64);
        chk("clamp_reads_left",  q_addr_f.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
